sdio_autoconfig: RTL

Zorro II AutoConfig responder for the SDIO function of the SF2000 accelerator, upstream of the SDIO access decoder. It answers AutoConfig reads in the $E8xxxx window while the config chain selects it. It latches the base address written by the OS, or accepts shut-up. It then drives `BASE_SDIO`, `SDIO_CONFIGURED_n` and `CFGOUT_n`, which hand the chain to the next board.

---
 rtl/sdio_autoconfig_pkg.sv | 36 +++
 rtl/sdio_autoconfig_rom.sv | 61 ++++++
 rtl/sdio_autoconfig.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/sdio_autoconfig_pkg.sv
// -----------------------------------------------------------------------------
// sdio_autoconfig_pkg
//   Shared types and constants for the SDIO AutoConfig responder.
//   - ac_state_e    : responder lifecycle (UNCONF -> CONFIGURED | SHUTUP)
//   - OFS_*         : A[6:1] values of the writable AutoConfig registers
//   - ER_TYPE/FLAGS : fixed er_Type / er_Flags bytes of this board
//   - AC_WINDOW     : A[23:16] of the AutoConfig space ($E8xxxx)
//   - is_plain_nibble() : offsets that are presented true (not inverted)
// -----------------------------------------------------------------------------
package sdio_autoconfig_pkg;

  typedef enum logic [1:0] {
    UNCONF     = 2'd0,
    CONFIGURED = 2'd1,
    SHUTUP     = 2'd2
  } ac_state_e;

  // A_LOW carries A[6:1], so each constant is the byte offset shifted right by 1.
  localparam logic [5:0] OFS_BASE_HI = 6'h24;  // $48
  localparam logic [5:0] OFS_BASE_LO = 6'h25;  // $4A
  localparam logic [5:0] OFS_SHUTUP  = 6'h26;  // $4C

  // Zorro II, diagnostic vector valid, 64 KB board.
  localparam logic [7:0] ER_TYPE  = 8'hD1;
  localparam logic [7:0] ER_FLAGS = 8'h00;

  localparam logic [7:0] AC_WINDOW = 8'hE8;

  // er_Type ($00/$02) and the $40/$42 control nibbles are read true;
  // every other AutoConfig nibble is stored and returned complemented.
  function automatic logic is_plain_nibble(input logic [5:0] a_low);
    return (a_low == 6'h00) || (a_low == 6'h01) ||
           (a_low == 6'h20) || (a_low == 6'h21);
  endfunction

endpackage : sdio_autoconfig_pkg

// File: rtl/sdio_autoconfig_rom.sv
// -----------------------------------------------------------------------------
// sdio_autoconfig_rom
//   Combinational AutoConfig nibble lookup. Each descriptor byte occupies two
//   consecutive A[6:1] slots: high nibble first, low nibble second.
//   Ports:
//     a_low  [5:0] in  : CPU A[6:1]
//     nibble [3:0] out : value to present on D[15:12] (inversion applied)
// -----------------------------------------------------------------------------
module sdio_autoconfig_rom
  import sdio_autoconfig_pkg::*;
#(
  parameter logic [7:0]  PRODUCT_ID   = 8'h03,
  parameter logic [15:0] MANUFACTURER = 16'h1337,
  parameter logic [31:0] SERIAL       = 32'h0000_0001,
  parameter logic [15:0] DIAG_VEC     = 16'h0040
) (
  input  logic [5:0] a_low,
  output logic [3:0] nibble
);

  logic [3:0] raw;

  always_comb begin
    // NOTE: every variable written in an always_comb gets a default first, so
    // no path through the case can leave it unassigned and infer a latch.
    raw = 4'h0;
    case (a_low)
      // $00/$02 er_Type
      6'h00: raw = ER_TYPE[7:4];
      6'h01: raw = ER_TYPE[3:0];
      // $04/$06 er_Product
      6'h02: raw = PRODUCT_ID[7:4];
      6'h03: raw = PRODUCT_ID[3:0];
      // $08/$0A er_Flags
      6'h04: raw = ER_FLAGS[7:4];
      6'h05: raw = ER_FLAGS[3:0];
      // $10..$16 er_Manufacturer
      6'h08: raw = MANUFACTURER[15:12];
      6'h09: raw = MANUFACTURER[11:8];
      6'h0A: raw = MANUFACTURER[7:4];
      6'h0B: raw = MANUFACTURER[3:0];
      // $18..$26 er_SerialNumber
      6'h0C: raw = SERIAL[31:28];
      6'h0D: raw = SERIAL[27:24];
      6'h0E: raw = SERIAL[23:20];
      6'h0F: raw = SERIAL[19:16];
      6'h10: raw = SERIAL[15:12];
      6'h11: raw = SERIAL[11:8];
      6'h12: raw = SERIAL[7:4];
      6'h13: raw = SERIAL[3:0];
      // $28..$2E er_InitDiagVec
      6'h14: raw = DIAG_VEC[15:12];
      6'h15: raw = DIAG_VEC[11:8];
      6'h16: raw = DIAG_VEC[7:4];
      6'h17: raw = DIAG_VEC[3:0];
      default: raw = 4'h0;
    endcase
    nibble = is_plain_nibble(a_low) ? raw : ~raw;
  end

endmodule : sdio_autoconfig_rom

// File: rtl/sdio_autoconfig.sv
// -----------------------------------------------------------------------------
// sdio_autoconfig
//   Zorro II AutoConfig responder for the SF2000 SDIO function. While the
//   config chain selects it, it answers reads in the $E8xxxx window with the
//   descriptor ROM, then takes either a base address ($4A then $48) or a
//   shut-up ($4C) and passes the chain on.
//   Ports:
//     C7M               in   7 MHz bus clock, all state on its rising edge
//     RESET_n           in   asynchronous active-low reset
//     A_HIGH[7:0]       in   CPU A[23:16]
//     A_LOW[5:0]        in   CPU A[6:1]
//     RW_n              in   1 = read, 0 = write
//     AS_CPU_n          in   CPU address strobe (asynchronous to C7M)
//     CFGIN_n           in   config chain in, 0 = our turn
//     D_IN[3:0]         in   CPU D[15:12] write nibble
//     D_OUT[3:0]        out  registered read nibble for D[15:12]
//     D_OE              out  registered drive enable for D[15:12]
//     BASE_SDIO[7:0]    out  assigned A[23:16] base
//     SDIO_CONFIGURED_n out  0 once a base is assigned
//     CFGOUT_n          out  config chain out, 0 once we are done
// -----------------------------------------------------------------------------
module sdio_autoconfig
  import sdio_autoconfig_pkg::*;
#(
  parameter logic [7:0]  PRODUCT_ID   = 8'h03,
  parameter logic [15:0] MANUFACTURER = 16'h1337,
  parameter logic [31:0] SERIAL       = 32'h0000_0001,
  parameter logic [15:0] DIAG_VEC     = 16'h0040
) (
  input  logic       C7M,
  input  logic       RESET_n,
  input  logic [7:0] A_HIGH,
  input  logic [5:0] A_LOW,
  input  logic       RW_n,
  input  logic       AS_CPU_n,
  input  logic       CFGIN_n,
  input  logic [3:0] D_IN,
  output logic [3:0] D_OUT,
  output logic       D_OE,
  output logic [7:0] BASE_SDIO,
  output logic       SDIO_CONFIGURED_n,
  output logic       CFGOUT_n
);

  // Address-strobe synchroniser; idles high so reset never looks like a cycle.
  logic      as_meta_q, as_meta_d;
  logic      as_s_q,    as_s_d;

  ac_state_e state_q,   state_d;
  logic [3:0] base_lo_q, base_lo_d;
  logic [7:0] base_q,    base_d;
  logic       conf_n_q,  conf_n_d;
  logic       cfgout_n_q, cfgout_n_d;
  logic       wr_done_q, wr_done_d;
  logic       d_oe_q,    d_oe_d;
  logic [3:0] d_out_q,   d_out_d;

  logic [3:0] rom_nibble;
  logic       sel;
  logic       wr_accept;

  sdio_autoconfig_rom #(
    .PRODUCT_ID  (PRODUCT_ID),
    .MANUFACTURER(MANUFACTURER),
    .SERIAL      (SERIAL),
    .DIAG_VEC    (DIAG_VEC)
  ) u_rom (
    .a_low (A_LOW),
    .nibble(rom_nibble)
  );

  // Only an unconfigured board that holds the chain answers the window.
  assign sel       = !as_s_q && (A_HIGH == AC_WINDOW) && !CFGIN_n && (state_q == UNCONF);
  // wr_done blocks a long strobe from committing the same write twice.
  assign wr_accept = sel && !RW_n && !wr_done_q;

  always_comb begin
    as_meta_d = AS_CPU_n;
    as_s_d    = as_meta_q;
    state_d   = state_q;
    base_lo_d = base_lo_q;
    base_d    = base_q;
    conf_n_d  = conf_n_q;
    wr_done_d = wr_done_q;
    d_oe_d    = sel && RW_n;
    d_out_d   = rom_nibble;

    if (wr_accept) begin
      wr_done_d = 1'b1;
      case (A_LOW)
        OFS_BASE_LO: base_lo_d = D_IN;
        OFS_BASE_HI: begin
          base_d   = {D_IN, base_lo_q};
          conf_n_d = 1'b0;
          state_d  = CONFIGURED;
        end
        OFS_SHUTUP:  state_d = SHUTUP;
        default:     ;
      endcase
    end

    if (as_s_q) wr_done_d = 1'b0;

    // Derived from the next state so the chain opens on the commit edge.
    cfgout_n_d = (state_d == UNCONF);
  end

  // NOTE: the reset is asynchronous (in the sensitivity list) so outputs drop
  // the moment RESET_n falls, without waiting for a C7M edge.
  always_ff @(posedge C7M or negedge RESET_n) begin
    if (!RESET_n) begin
      as_meta_q  <= 1'b1;
      as_s_q     <= 1'b1;
      state_q    <= UNCONF;
      base_lo_q  <= 4'h0;
      base_q     <= 8'h00;
      conf_n_q   <= 1'b1;
      cfgout_n_q <= 1'b1;
      wr_done_q  <= 1'b0;
      d_oe_q     <= 1'b0;
      d_out_q    <= 4'h0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples its pre-edge inputs regardless of statement order.
      as_meta_q  <= as_meta_d;
      as_s_q     <= as_s_d;
      state_q    <= state_d;
      base_lo_q  <= base_lo_d;
      base_q     <= base_d;
      conf_n_q   <= conf_n_d;
      cfgout_n_q <= cfgout_n_d;
      wr_done_q  <= wr_done_d;
      d_oe_q     <= d_oe_d;
      d_out_q    <= d_out_d;
    end
  end

  assign D_OUT             = d_out_q;
  assign D_OE              = d_oe_q;
  assign BASE_SDIO         = base_q;
  assign SDIO_CONFIGURED_n = conf_n_q;
  assign CFGOUT_n          = cfgout_n_q;

endmodule : sdio_autoconfig
